// File: rtl/slv_disp_pkg.sv
// Shared types and route-mode encodings for the slave dispatcher.
package slv_disp_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned PV_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } disp_state_e;

  localparam logic [MODE_W-1:0] MODE_SLV0  = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SLV1  = 2'd1;
  localparam logic [MODE_W-1:0] MODE_BCAST = 2'd2;
  localparam logic [MODE_W-1:0] MODE_RR    = 2'd3;

endpackage

// File: rtl/slv_out_reg.sv
// One-deep per-slave output holding register: loads on accept, clears on slave ready.
module slv_out_reg
  import slv_disp_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              ready_i,
  input  logic [MODE_W-1:0] mode_i,
  input  logic [PV_W-1:0]   proc_val_i,
  input  logic [DW-1:0]     data_i,
  output logic              valid_o,
  output logic [MODE_W-1:0] mode_o,
  output logic [PV_W-1:0]   proc_val_o,
  output logic [DW-1:0]     data_o
);

  logic              valid_q;
  logic [MODE_W-1:0] mode_q;
  logic [PV_W-1:0]   proc_val_q;
  logic [DW-1:0]     data_q;

  // A load only happens when the slot is free, so held payload never changes under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      mode_q     <= '0;
      proc_val_q <= '0;
      data_q     <= '0;
    end else if (load_i) begin
      valid_q    <= 1'b1;
      mode_q     <= mode_i;
      proc_val_q <= proc_val_i;
      data_q     <= data_i;
    end else if (ready_i) begin
      valid_q    <= 1'b0;
    end
  end

  assign valid_o    = valid_q;
  assign mode_o     = mode_q;
  assign proc_val_o = proc_val_q;
  assign data_o     = data_q;

endmodule

// File: rtl/slv_dispatcher.sv
// Distributes source words to two slaves by per-word route mode and
// signals completion once a full frame has been delivered.
module slv_dispatcher
  import slv_disp_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned FRAME_WORDS = 100,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [MODE_W-1:0] src_mode,
  input  logic [PV_W-1:0]   src_proc_val,
  input  logic [DW-1:0]     src_data,
  output logic              slv0_data_valid,
  output logic [MODE_W-1:0] slv0_mode,
  output logic [PV_W-1:0]   slv0_proc_valid,
  output logic [DW-1:0]     slv0_data,
  input  logic              slv0_ready,
  output logic              slv1_data_valid,
  output logic [MODE_W-1:0] slv1_mode,
  output logic [PV_W-1:0]   slv1_proc_valid,
  output logic [DW-1:0]     slv1_data,
  input  logic              slv1_ready,
  output logic              disp_cmplt,
  output logic              busy,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  disp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_q, rr_d;
  logic             cmplt_q, cmplt_d;
  logic             busy_q, busy_d;

  logic free0, free1;
  logic need0, need1;
  logic drop;
  logic accept;
  logic load0, load1;
  logic valid0_nxt, valid1_nxt;

  // Route decode and source handshake; broadcast needs both slots so it is never split.
  always_comb begin
    need0 = 1'b0;
    need1 = 1'b0;
    free0 = !slv0_data_valid || slv0_ready;
    free1 = !slv1_data_valid || slv1_ready;
    drop  = (src_proc_val == '0);
    case (src_mode)
      MODE_SLV0:  need0 = 1'b1;
      MODE_SLV1:  need1 = 1'b1;
      MODE_BCAST: begin
        need0 = 1'b1;
        need1 = 1'b1;
      end
      default: begin
        need0 = !rr_q;
        need1 = rr_q;
      end
    endcase
    src_ready  = (state_q == RUN) &&
                 (drop || ((!need0 || free0) && (!need1 || free1)));
    accept     = src_valid && src_ready;
    load0      = accept && !drop && need0;
    load1      = accept && !drop && need1;
    valid0_nxt = load0 || (slv0_data_valid && !slv0_ready);
    valid1_nxt = load1 || (slv1_data_valid && !slv1_ready);
  end

  // Frame sequencing; completion is registered so it lines up with the final DRAIN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!slv0_data_valid && !slv1_data_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (accept && (src_mode == MODE_RR)) rr_d = !rr_q;
    cmplt_d = (state_d == DRAIN) && !valid0_nxt && !valid1_nxt;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rr_q    <= 1'b0;
      cmplt_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      cmplt_q <= cmplt_d;
      busy_q  <= busy_d;
    end
  end

  assign disp_cmplt = cmplt_q;
  assign busy       = busy_q;
  assign word_cnt   = cnt_q;

  slv_out_reg #(.DW(DW)) u_out0 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load0),
    .ready_i    (slv0_ready),
    .mode_i     (src_mode),
    .proc_val_i (src_proc_val),
    .data_i     (src_data),
    .valid_o    (slv0_data_valid),
    .mode_o     (slv0_mode),
    .proc_val_o (slv0_proc_valid),
    .data_o     (slv0_data)
  );

  slv_out_reg #(.DW(DW)) u_out1 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load1),
    .ready_i    (slv1_ready),
    .mode_i     (src_mode),
    .proc_val_i (src_proc_val),
    .data_i     (src_data),
    .valid_o    (slv1_data_valid),
    .mode_o     (slv1_mode),
    .proc_val_o (slv1_proc_valid),
    .data_o     (slv1_data)
  );

endmodule

// File: doc/slv_dispatcher.md
Name: slv_dispatcher

Overview:
Master-side distributor feeding the two processing slaves: the opposite direction of the arbiter's slave-to-master merge. Pops words from the source FIFO read side (valid/ready), routes each to slave 0, slave 1, both, or alternating by per-word mode, and holds it in a per-slave output register until that slave's ready. Counts words per frame and pulses completion once the frame is fully delivered.

Parameters:
DW, 32, data word width
FRAME_WORDS, 100, words accepted per frame (min 1)
CNT_W, 8, width of word counter (must satisfy 2**CNT_W > FRAME_WORDS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin frame; honoured only in IDLE
src_valid  in  1  source word available
src_ready  out  1  word accepted when src_valid && src_ready
src_mode  in  2  route: 0 slv0, 1 slv1, 2 broadcast, 3 round-robin
src_proc_val  in  8  per-byte process mask
src_data  in  DW  pixel word
slv0_data_valid  out  1  slave 0 output holds a word
slv0_mode  out  2  mode carried with the word
slv0_proc_valid  out  8  mask carried with the word
slv0_data  out  DW  word to slave 0
slv0_ready  in  1  slave 0 takes word this cycle
slv1_data_valid, slv1_mode, slv1_proc_valid, slv1_data  out  1/2/8/DW  same for slave 1
slv1_ready  in  1  slave 1 takes word
disp_cmplt  out  1  one-cycle pulse, frame delivered
busy  out  1  high when not IDLE
word_cnt  out  CNT_W  words accepted this frame

Behaviour:
- Reset (sync, rst=1 at edge): state IDLE; all outputs 0; rr pointer 0; word_cnt 0; output registers invalid. Reset mid-frame discards held words without handshake.
- States: IDLE -> RUN on start; RUN -> DRAIN on acceptance of word FRAME_WORDS; DRAIN -> IDLE when slv0_data_valid=0 and slv1_data_valid=0, disp_cmplt=1 on that transition cycle only.
- Slot free_k = !slvk_data_valid || slvk_ready.
- src_ready (combinational) = state==RUN && target free: mode0 free_0; mode1 free_1; mode2 free_0 && free_1 (atomic, never partial); mode3 free of slave selected by rr.
- src_proc_val==0: word consumed and counted but not forwarded; src_ready=1 in RUN regardless of slots.
- Accepted word loads target register(s); valid rises next cycle (latency 1). Register cleared when slvk_ready && no new load same cycle; load and drain same cycle keeps valid=1 with new word. Full throughput one word/cycle when ready held high.
- mode3: rr toggles on each accepted mode-3 word (incl. dropped ones); other modes leave rr unchanged. mode field forwarded unmodified.
- Outputs stable while valid && !ready.
- word_cnt increments per acceptance; cleared on entry to RUN. Start in RUN/DRAIN ignored. Start and rst together: rst wins.
- FRAME_WORDS=1: accept one word, go straight to DRAIN.

Decomposition:
- Package slv_disp_pkg: state enum (IDLE, RUN, DRAIN), route mode constants (MODE_SLV0=0, MODE_SLV1=1, MODE_BCAST=2, MODE_RR=3).
- Sub-module slv_out_reg: one output register with load/ready/valid logic, instanced twice.

Test Plan:
- Reset then start, 4 words mode0 data 11111111..44444444, slv0_ready=1 -> each appears on slv0_data one cycle after acceptance, slv1_data_valid stays 0, word_cnt=4.
- Mode2 word AABBCCDD, slv0_ready=1, slv1_ready=0 for 3 cycles -> next mode2 word stalls (src_ready=0) until slv1_ready; both outputs held at AABBCCDD.
- Six mode3 words 1..6, both ready -> slv0 gets 1,3,5; slv1 gets 2,4,6; rr=0 at end.
- proc_val=8'h00 word 0xDEADBEEF in RUN with slaves stalled -> accepted, counted, never appears on either slave.
- FRAME_WORDS=3, slv1_ready=0 during last word -> DRAIN holds, disp_cmplt pulses exactly one cycle after slv1_ready, then busy=0 and src_ready=0.
- rst asserted with words held in both registers -> next cycle all valids 0, state IDLE, no cmplt pulse.
